// File: rtl/simple_if_rd_arb.sv
// Round-robin read arbiter: NUM_REQ requesters share one simple-bus read slave,
// one outstanding transaction at a time, with a watchdog for silent slaves.
module simple_if_rd_arb #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_BIT_WIDTH = 2,
    parameter int DATA_BIT_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              i_clk,
    input  logic                              i_sync_rst,
    input  logic [NUM_REQ-1:0]                i_req,
    input  logic [NUM_REQ*ADDR_BIT_WIDTH-1:0] i_addr,
    output logic [NUM_REQ-1:0]                o_ack,
    output logic [NUM_REQ-1:0]                o_rd_vld,
    output logic [DATA_BIT_WIDTH-1:0]         o_rd_data,
    output logic                              o_rd_err,
    output logic                              o_busy,
    output logic                              o_rd_req,
    output logic [ADDR_BIT_WIDTH-1:0]         o_addr,
    input  logic [DATA_BIT_WIDTH-1:0]         i_rd_data,
    input  logic                              i_rd_vld
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t                    state, state_nxt;
    logic [PTR_W-1:0]          ptr, ptr_nxt;
    logic [PTR_W-1:0]          grant, grant_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic [NUM_REQ-1:0]        ack_nxt;
    logic [NUM_REQ-1:0]        rd_vld_nxt;
    logic [DATA_BIT_WIDTH-1:0] rd_data_nxt;
    logic                      rd_err_nxt;
    logic                      busy_nxt;
    logic                      rd_req_nxt;
    logic [ADDR_BIT_WIDTH-1:0] addr_nxt;

    logic                      found;
    logic [PTR_W-1:0]          pick;
    logic [PTR_W-1:0]          ptr_after;
    logic [ADDR_BIT_WIDTH-1:0] pick_addr;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // First active requester at or above ptr, wrapping around.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        pick_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && i_req[(int'(ptr) + i) % NUM_REQ]) begin
                found     = 1'b1;
                pick      = PTR_W'((int'(ptr) + i) % NUM_REQ);
                pick_addr = i_addr[((int'(ptr) + i) % NUM_REQ) * ADDR_BIT_WIDTH +: ADDR_BIT_WIDTH];
            end
        end
        ptr_after = (pick == PTR_LAST) ? '0 : pick + PTR_W'(1);
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        grant_nxt   = grant;
        cnt_nxt     = cnt;
        ack_nxt     = '0;
        rd_vld_nxt  = '0;
        rd_data_nxt = o_rd_data;
        rd_err_nxt  = o_rd_err;
        rd_req_nxt  = 1'b0;
        addr_nxt    = o_addr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt  = ISSUE;
                    grant_nxt  = pick;
                    ptr_nxt    = ptr_after;
                    addr_nxt   = pick_addr;
                    ack_nxt    = onehot(pick);
                    rd_req_nxt = 1'b1;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
                cnt_nxt   = '0;
            end
            WAIT: begin
                if (i_rd_vld) begin
                    state_nxt   = IDLE;
                    rd_vld_nxt  = onehot(grant);
                    rd_data_nxt = i_rd_data;
                    rd_err_nxt  = 1'b0;
                end else if (TIMEOUT_CYCLES > 0 && cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    rd_vld_nxt  = onehot(grant);
                    rd_data_nxt = '0;
                    rd_err_nxt  = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            cnt       <= '0;
            o_ack     <= '0;
            o_rd_vld  <= '0;
            o_rd_data <= '0;
            o_rd_err  <= 1'b0;
            o_busy    <= 1'b0;
            o_rd_req  <= 1'b0;
            o_addr    <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant     <= grant_nxt;
            cnt       <= cnt_nxt;
            o_ack     <= ack_nxt;
            o_rd_vld  <= rd_vld_nxt;
            o_rd_data <= rd_data_nxt;
            o_rd_err  <= rd_err_nxt;
            o_busy    <= busy_nxt;
            o_rd_req  <= rd_req_nxt;
            o_addr    <= addr_nxt;
        end
    end

endmodule

// File: doc/simple_if_rd_arb.md
# simple_if_rd_arb

Round-robin read arbiter that lets `NUM_REQ` requesters share one simple-bus read slave. It accepts one request at a time, issues it downstream, waits for the slave's read data and routes it back to the granted requester. A watchdog ends transactions the slave never answers. It sits between several master-side modules and a single slave on the same clock domain.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `ADDR_BIT_WIDTH`, 2: address width.
- `DATA_BIT_WIDTH`, 8: read data width.
- `TIMEOUT_CYCLES`, 16: maximum number of WAIT cycles before an error response. 0 disables the timeout.

Ports:
- `i_clk` input 1: clock. Single clock domain.
- `i_sync_rst` input 1: reset, synchronous, active-high.
- `i_req` input `NUM_REQ`: per-requester read request level.
- `i_addr` input `NUM_REQ*ADDR_BIT_WIDTH`: per-requester address. Requester k uses slice `[k*ADDR_BIT_WIDTH +: ADDR_BIT_WIDTH]`.
- `o_ack` output `NUM_REQ`: one-cycle pulse marking the accepted requester.
- `o_rd_vld` output `NUM_REQ`: one-cycle pulse marking the requester whose response is on `o_rd_data`.
- `o_rd_data` output `DATA_BIT_WIDTH`: response data, shared by all requesters.
- `o_rd_err` output 1: qualifies `o_rd_vld`; 1 means timeout, with data forced to 0.
- `o_busy` output 1: high whenever the state is not IDLE.
- `o_rd_req` output 1: one-cycle downstream read strobe.
- `o_addr` output `ADDR_BIT_WIDTH`: downstream address, held from ISSUE through WAIT.
- `i_rd_data` input `DATA_BIT_WIDTH`: slave read data.
- `i_rd_vld` input 1: slave data-valid pulse.

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT. All outputs are registered.
- **IDLE:** if `i_req` is nonzero, the block does the following, then moves to ISSUE:
  - Chooses grant index g by searching from pointer `ptr` upward, wrapping modulo `NUM_REQ`.
  - Latches `i_addr` slice g into `o_addr`.
  - Sets `ptr <= (g+1) mod NUM_REQ`.
- **ISSUE** (exactly 1 cycle): `o_rd_req=1` and `o_ack[g]=1`, then the FSM moves to WAIT and clears the timeout counter. `i_rd_vld` is ignored in this state.
- **WAIT:** `i_req` is ignored. `o_addr` is held.
  - `i_rd_vld=1`: next cycle `o_rd_vld[g]=1`, `o_rd_data=i_rd_data`, `o_rd_err=0`, and the state is IDLE.
  - Otherwise the counter increments. If `TIMEOUT_CYCLES>0` and this is the `TIMEOUT_CYCLES`-th WAIT cycle without valid: next cycle `o_rd_vld[g]=1`, `o_rd_err=1`, `o_rd_data=0`, and the state is IDLE.
  - If `i_rd_vld` arrives on the `TIMEOUT_CYCLES`-th cycle, the transaction is a success, not a timeout.
- The IDLE cycle that carries the `o_rd_vld` pulse also arbitrates. A requester holding `i_req` is re-served back-to-back, subject to round-robin order.
- A requester must deassert `i_req` in the cycle after `o_ack`, unless it wants another read.
- A late `i_rd_vld` after a timeout (arriving in IDLE or ISSUE) is dropped with no side effects.
- The timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1. It saturates and never wraps.
- Only one transaction is outstanding at any time.

## Timing
- Reset values:
  - state IDLE, `ptr=0`.
  - `o_ack`, `o_rd_vld`, `o_rd_data`, `o_rd_err`, `o_busy`, `o_rd_req` and `o_addr` all 0.
- Reset asserted mid-transaction aborts it. No `o_rd_vld` is produced, and the first post-reset grant starts searching from requester 0.
- Request sampled in IDLE at cycle 0 → `o_rd_req` and `o_ack` at cycle 1. WAIT runs from cycle 2.
- Earliest `i_rd_vld` is at cycle 2 → `o_rd_vld` at cycle 3.
- Minimum period is 3 cycles per transaction.
- `o_busy` is high from cycle 1 until the cycle before `o_rd_vld`; it is low in the cycle `o_rd_vld` is high.
- Timeout response arrives at cycle 2+`TIMEOUT_CYCLES`.

## Test plan
- **Single request:** reset, then `i_req=4'b0010` with addr1=2. Slave answers 0xA5 two cycles after `o_rd_req`.
  - Expect `o_ack=0010` and `o_addr=2` at cycle 1.
  - Expect `o_rd_vld=0010`, `o_rd_data=0xA5` and `o_rd_err=0` at cycle 4.
- **Round-robin:** `i_req=4'b1111` held continuously, slave responding immediately.
  - Expect grant order 0,1,2,3,0, with `o_ack` pulses 3 cycles apart.
- **Pointer wrap:** after a grant to requester 3, `i_req=4'b0101` → grant 0, then grant 2.
- **Timeout:** `TIMEOUT_CYCLES=4`, slave silent.
  - Expect `o_rd_vld[g]=1`, `o_rd_err=1` and `o_rd_data=0` at cycle 6.
  - Inject a late `i_rd_vld` at cycle 7 → no output change.
- **Boundary:** `i_rd_vld` exactly on the 4th WAIT cycle (cycle 5) → success at cycle 6 with `o_rd_err=0`.
- **Mid-operation reset:** assert reset in WAIT → all outputs 0 next cycle. Then `i_req=4'b1000` → grant 3, and `i_req=4'b1001` → grant 0 first.
